// File: rtl/udp_payload_fifo.sv
// udp_payload_fifo
//   Payload buffer in front of udp_send. A producer writes 32-bit words, and
//   they come out as a first-word-fall-through byte stream in network order:
//   bits [31:24] of each word are sent first. Once a full datagram of
//   i_pkt_len bytes is buffered, the block raises a one-cycle send request.
//   It then tracks that datagram until its last byte has been read.
//
//   Strobe semantics (both sides): i_wr and i_rd are single-cycle strobes.
//   A strobe is accepted on the rising clk edge when its side can take it:
//   a write needs !o_full, and a read needs !o_empty. o_rd_data is the byte
//   that an accepted read consumes. A strobe that cannot be accepted is
//   discarded and sets the matching sticky error flag.
//
// Parameters
//   ADDR_W        word-address width, depth = 2**ADDR_W words
// Ports
//   clk           tx clock
//   rst_n         asynchronous reset, active low
//   i_wr_data     write word
//   i_wr          write strobe
//   o_full        no free word slot
//   o_rd_data     head byte (FWFT), 0 while empty
//   i_rd          read/advance strobe
//   o_empty       no unread byte
//   o_level       unread byte count
//   i_pkt_len     datagram payload length in bytes
//   o_send_req    one-cycle datagram-ready pulse
//   o_busy        datagram in flight
//   o_overflow    sticky: write while full
//   o_underrun    sticky: read while empty
//   i_clr_err     clears both sticky flags (a same-cycle new error wins)
//   o_state       FSM state for debug observation (0 IDLE, 1 REQ, 2 SEND)
//
// Build option
//   UDP_FIFO_TEST_PATTERN_EN: the read side becomes a free-running byte
//   counter, o_empty is held 0, and requests repeat whenever idle.

module udp_payload_fifo #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       i_wr_data,
   input  logic              i_wr,
   output logic              o_full,
   output logic [7:0]        o_rd_data,
   input  logic              i_rd,
   output logic              o_empty,
   output logic [ADDR_W+2:0] o_level,
   input  logic [15:0]       i_pkt_len,
   output logic              o_send_req,
   output logic              o_busy,
   output logic              o_overflow,
   output logic              o_underrun,
   input  logic              i_clr_err,
   output logic [1:0]        o_state
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SEND = 2'd2
   } state_t;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   words;
   logic [1:0]        bsel;
   logic [ADDR_W+2:0] level;
   logic              full;
   logic              wr_ok;
   logic              rd_ok;     // read that consumes a FIFO byte
   logic              cnt_rd;    // read that counts toward a datagram
   logic              ur_set;
   logic              req_cond;
   logic              release_w;
   state_t            state;
   logic [15:0]       remain;

   // A partly read head word still holds its slot, so the level subtracts
   // the bytes already consumed from it.
   assign level     = {words, 2'b00} - {{(ADDR_W+1){1'b0}}, bsel};
   assign full      = (words == (ADDR_W+1)'(DEPTH));
   assign wr_ok     = i_wr && !full;
   assign release_w = rd_ok && (bsel == 2'd3);

   assign o_full  = full;
   assign o_level = level;
   assign o_state = state;

`ifdef UDP_FIFO_TEST_PATTERN_EN
   logic [7:0] pat_cnt;

   assign rd_ok     = 1'b0;
   assign cnt_rd    = i_rd;
   assign ur_set    = 1'b0;
   assign o_empty   = 1'b0;
   assign o_rd_data = pat_cnt;
   assign req_cond  = (i_pkt_len != 16'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pat_cnt <= 8'd0;
      else if (i_rd) pat_cnt <= pat_cnt + 8'd1;
   end
`else
   logic        fifo_empty;
   logic [31:0] head;

   assign fifo_empty = (level == '0);
   assign rd_ok      = i_rd && !fifo_empty;
   assign cnt_rd     = rd_ok;
   assign ur_set     = i_rd && fifo_empty;
   assign o_empty    = fifo_empty;
   assign head       = mem[rd_ptr];
   // A request needs the whole datagram to be buffered already. A length
   // larger than the capacity can therefore never issue a request.
   assign req_cond   = (i_pkt_len != 16'd0) && (32'(level) >= 32'(i_pkt_len));

   // Combinational read of the head word, so a byte is valid in the cycle
   // right after it was written into an empty FIFO.
   always_comb begin
      o_rd_data = 8'h00;
      if (!fifo_empty) begin
         case (bsel)
            2'd0:    o_rd_data = head[31:24];
            2'd1:    o_rd_data = head[23:16];
            2'd2:    o_rd_data = head[15:8];
            default: o_rd_data = head[7:0];
         endcase
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         words  <= '0;
         bsel   <= 2'd0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) begin
            bsel <= bsel + 2'd1;
            if (release_w) rd_ptr <= rd_ptr + 1'b1;
         end
         if (wr_ok && !release_w)      words <= words + 1'b1;
         else if (release_w && !wr_ok) words <= words - 1'b1;
      end
   end

   // Sticky error flags. Setting has priority over clearing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_overflow <= 1'b0;
         o_underrun <= 1'b0;
      end else begin
         if (i_wr && full) o_overflow <= 1'b1;
         else if (i_clr_err) o_overflow <= 1'b0;
         if (ur_set) o_underrun <= 1'b1;
         else if (i_clr_err) o_underrun <= 1'b0;
      end
   end

   // Datagram sequencer. The outputs are registered so that they line up
   // with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         o_send_req <= 1'b0;
         o_busy     <= 1'b0;
         remain     <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_cond) begin
                  state      <= REQ;
                  o_send_req <= 1'b1;
               end
            end
            REQ: begin
               o_send_req <= 1'b0;
               o_busy     <= 1'b1;
               remain     <= i_pkt_len;
               state      <= SEND;
            end
            SEND: begin
               if (cnt_rd) begin
                  // A length of 0 loaded by a late change must not wrap.
                  if (remain <= 16'd1) begin
                     state  <= IDLE;
                     o_busy <= 1'b0;
                  end else begin
                     remain <= remain - 16'd1;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               o_send_req <= 1'b0;
               o_busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_udp_payload_fifo.sv
// Testbench for udp_payload_fifo, built with ADDR_W=2 (4 words / 16 bytes).
// The small depth makes it easy to reach the full, overflow and
// capacity-limit cases.

module tb_udp_payload_fifo;

   logic        clk;
   logic        rst_n;
   logic [31:0] i_wr_data;
   logic        i_wr;
   logic        o_full;
   logic [7:0]  o_rd_data;
   logic        i_rd;
   logic        o_empty;
   logic [4:0]  o_level;
   logic [15:0] i_pkt_len;
   logic        o_send_req;
   logic        o_busy;
   logic        o_overflow;
   logic        o_underrun;
   logic        i_clr_err;
   logic [1:0]  o_state;

   int n_vec = 0;
   int n_err = 0;

`ifdef UDP_FIFO_TEST_PATTERN_EN
   localparam logic EXP_EMPTY = 1'b0;
`else
   localparam logic EXP_EMPTY = 1'b1;
`endif

   udp_payload_fifo #(.ADDR_W(2)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_data  (i_wr_data),
      .i_wr       (i_wr),
      .o_full     (o_full),
      .o_rd_data  (o_rd_data),
      .i_rd       (i_rd),
      .o_empty    (o_empty),
      .o_level    (o_level),
      .i_pkt_len  (i_pkt_len),
      .o_send_req (o_send_req),
      .o_busy     (o_busy),
      .o_overflow (o_overflow),
      .o_underrun (o_underrun),
      .i_clr_err  (i_clr_err),
      .o_state    (o_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [31:0] w);
      i_wr = 1'b1;
      i_wr_data = w;
      tick();
      i_wr = 1'b0;
   endtask

   task automatic read_byte();
      i_rd = 1'b1;
      tick();
      i_rd = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_wr_data = '0;
      i_pkt_len = 16'd0; i_clr_err = 1'b0;
      #22 rst_n = 1'b1;
      tick();
      n_vec++; if (o_empty !== EXP_EMPTY) begin n_err++; $display("FAIL reset_empty: got %b want %b", o_empty, EXP_EMPTY); end
      n_vec++; if (o_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", o_full); end
      n_vec++; if (o_level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", o_level); end
      n_vec++; if (o_send_req !== 1'b0) begin n_err++; $display("FAIL reset_send_req: got %b want 0", o_send_req); end
      n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
      n_vec++; if (o_underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b want 0", o_underrun); end
      n_vec++; if (o_rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h want 00", o_rd_data); end
   endtask

   task automatic test_basic();
      write_word(32'h01020304);
      n_vec++; if (o_empty !== 1'b0) begin n_err++; $display("FAIL basic_nonempty: got %b want 0", o_empty); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (o_rd_data !== 8'(i + 1)) begin n_err++; $display("FAIL basic_data[%0d]: got %h want %h", i, o_rd_data, 8'(i + 1)); end
         n_vec++; if (o_level !== 5'(4 - i)) begin n_err++; $display("FAIL basic_level[%0d]: got %0d want %0d", i, o_level, 4 - i); end
         read_byte();
      end
      n_vec++; if (o_level !== 5'd0) begin n_err++; $display("FAIL basic_level_end: got %0d want 0", o_level); end
      n_vec++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL basic_empty_end: got %b want 1", o_empty); end
      n_vec++; if (o_underrun !== 1'b0) begin n_err++; $display("FAIL basic_underrun: got %b want 0", o_underrun); end
   endtask

   task automatic test_full_overflow();
      logic [31:0] wv [5];
      logic [31:0] w;
      logic [7:0]  eb;
      wv[0] = 32'h11121314; wv[1] = 32'h21222324; wv[2] = 32'h31323334;
      wv[3] = 32'h41424344; wv[4] = 32'h51525354;
      for (int i = 0; i < 3; i++) write_word(wv[i]);
      n_vec++; if (o_full !== 1'b0) begin n_err++; $display("FAIL full_after3: got %b want 0", o_full); end
      write_word(wv[3]);
      n_vec++; if (o_full !== 1'b1) begin n_err++; $display("FAIL full_after4: got %b want 1", o_full); end
      n_vec++; if (o_level !== 5'd16) begin n_err++; $display("FAIL full_level: got %0d want 16", o_level); end
      write_word(wv[4]);
      n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", o_overflow); end
      n_vec++; if (o_level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d want 16", o_level); end
      // A new overflow in the same cycle as the clear keeps the flag set.
      i_clr_err = 1'b1; write_word(32'hFFFFFFFF); i_clr_err = 1'b0;
      n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_beats_clr: got %b want 1", o_overflow); end
      i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
      n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", o_overflow); end
      for (int i = 0; i < 16; i++) begin
         w = wv[i / 4];
         eb = 8'(w >> (8 * (3 - (i % 4))));
         n_vec++; if (o_rd_data !== eb) begin n_err++; $display("FAIL full_readback[%0d]: got %h want %h", i, o_rd_data, eb); end
         i_rd = 1'b1;
         // Write into a full FIFO alongside a word-releasing read: still dropped.
         if (i == 3) begin i_wr = 1'b1; i_wr_data = 32'hDEADBEEF; end
         tick();
         i_rd = 1'b0; i_wr = 1'b0;
         if (i == 3) begin
            n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_release_wr: got %b want 1", o_overflow); end
            n_vec++; if (o_level !== 5'd12) begin n_err++; $display("FAIL release_level: got %0d want 12", o_level); end
            n_vec++; if (o_full !== 1'b0) begin n_err++; $display("FAIL release_full: got %b want 0", o_full); end
         end
      end
      n_vec++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL full_drained: got %b want 1", o_empty); end
      i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
   endtask

   task automatic test_pkt_req();
      int pulses;
      i_pkt_len = 16'd8;
      write_word(32'hA0A1A2A3);
      n_vec++; if (o_send_req !== 1'b0) begin n_err++; $display("FAIL req_early1: got %b want 0", o_send_req); end
      write_word(32'hA4A5A6A7);
      n_vec++; if (o_level !== 5'd8) begin n_err++; $display("FAIL req_level8: got %0d want 8", o_level); end
      n_vec++; if (o_send_req !== 1'b0) begin n_err++; $display("FAIL req_early2: got %b want 0", o_send_req); end
      tick();
      n_vec++; if (o_send_req !== 1'b1) begin n_err++; $display("FAIL req_pulse: got %b want 1", o_send_req); end
      n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL req_busy_in_req: got %b want 0", o_busy); end
      tick();
      n_vec++; if (o_send_req !== 1'b0) begin n_err++; $display("FAIL req_one_cycle: got %b want 0", o_send_req); end
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL send_busy[%0d]: got %b want 1", i, o_busy); end
         n_vec++; if (o_rd_data !== 8'(8'hA0 + i)) begin n_err++; $display("FAIL send_data[%0d]: got %h want %h", i, o_rd_data, 8'(8'hA0 + i)); end
         read_byte();
         if (o_send_req) pulses++;
      end
      n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL send_busy_drop: got %b want 0", o_busy); end
      write_word(32'hB0B1B2B3);
      for (int i = 0; i < 4; i++) begin tick(); if (o_send_req) pulses++; end
      n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL req_no_extra: got %0d pulses want 0", pulses); end
      write_word(32'hB4B5B6B7);
      tick();
      n_vec++; if (o_send_req !== 1'b1) begin n_err++; $display("FAIL req_second: got %b want 1", o_send_req); end
      tick();
      for (int i = 0; i < 8; i++) read_byte();
      n_vec++; if (o_busy !== 1'b0 || o_empty !== 1'b1) begin n_err++; $display("FAIL second_done: got busy %b empty %b want 0 1", o_busy, o_empty); end
      // Longer than capacity: never requests, even when full.
      i_pkt_len = 16'd20;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin write_word(32'hC0C1C2C3 + 32'(i)); if (o_send_req) pulses++; end
      for (int i = 0; i < 5; i++) begin tick(); if (o_send_req) pulses++; end
      n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL req_over_capacity: got %0d pulses want 0", pulses); end
      // Length equal to capacity; a change during SEND is ignored.
      i_pkt_len = 16'd16;
      tick();
      n_vec++; if (o_send_req !== 1'b1) begin n_err++; $display("FAIL req_capacity: got %b want 1", o_send_req); end
      tick();
      i_pkt_len = 16'd4;
      for (int i = 0; i < 16; i++) begin
         read_byte();
         n_vec++; if (o_busy !== (i < 15)) begin n_err++; $display("FAIL len_change_busy[%0d]: got %b want %b", i, o_busy, (i < 15)); end
      end
      i_pkt_len = 16'd0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0]  exp_q [$];
      logic [31:0] w;
      int          k;
      k = 0;
      w = {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)};
      write_word(w);
      for (int b = 3; b >= 0; b--) exp_q.push_back(8'(w >> (8 * b)));
      for (int i = 0; i < 100; i++) begin
         i_rd = 1'b1;
         if (i % 4 == 3) begin
            k++;
            w = {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)};
            i_wr = 1'b1; i_wr_data = w;
            for (int b = 3; b >= 0; b--) exp_q.push_back(8'(w >> (8 * b)));
         end
         n_vec++; if (o_rd_data !== exp_q[0]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, o_rd_data, exp_q[0]); end
         tick();
         i_wr = 1'b0;
         void'(exp_q.pop_front());
         if (i % 4 == 3) begin
            n_vec++; if (o_level !== 5'd4 || o_empty !== 1'b0) begin n_err++; $display("FAIL b2b_level[%0d]: got %0d empty %b want 4 0", i, o_level, o_empty); end
         end
      end
      i_rd = 1'b0;
      while (exp_q.size() > 0) begin
         n_vec++; if (o_rd_data !== exp_q[0]) begin n_err++; $display("FAIL b2b_drain: got %h want %h", o_rd_data, exp_q[0]); end
         read_byte();
         void'(exp_q.pop_front());
      end
      n_vec++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", o_empty); end
   endtask

   task automatic test_underrun();
      logic [31:0] w;
      read_byte();
      n_vec++; if (o_underrun !== 1'b1) begin n_err++; $display("FAIL underrun_set: got %b want 1", o_underrun); end
      n_vec++; if (o_level !== 5'd0 || o_empty !== 1'b1) begin n_err++; $display("FAIL underrun_level: got %0d empty %b want 0 1", o_level, o_empty); end
      w = 32'hCAFEF00D;
      write_word(w);
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (o_rd_data !== 8'(w >> (8 * (3 - i)))) begin n_err++; $display("FAIL underrun_ptr[%0d]: got %h want %h", i, o_rd_data, 8'(w >> (8 * (3 - i)))); end
         read_byte();
      end
      i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
      n_vec++; if (o_underrun !== 1'b0) begin n_err++; $display("FAIL underrun_clr: got %b want 0", o_underrun); end
      i_clr_err = 1'b1; read_byte(); i_clr_err = 1'b0;
      n_vec++; if (o_underrun !== 1'b1) begin n_err++; $display("FAIL underrun_set_beats_clr: got %b want 1", o_underrun); end
      i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
   endtask

   task automatic test_reset_mid_send();
      i_pkt_len = 16'd4;
      write_word(32'h55667788);
      tick();
      tick();
      n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL mid_send_busy: got %b want 1", o_busy); end
      read_byte();
      read_byte();
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (o_busy !== 1'b0 || o_send_req !== 1'b0) begin n_err++; $display("FAIL mid_rst_fsm: got busy %b req %b want 0 0", o_busy, o_send_req); end
      n_vec++; if (o_level !== 5'd0 || o_empty !== 1'b1 || o_full !== 1'b0) begin n_err++; $display("FAIL mid_rst_fifo: got level %0d empty %b full %b want 0 1 0", o_level, o_empty, o_full); end
      n_vec++; if (o_rd_data !== 8'h00 || o_overflow !== 1'b0 || o_underrun !== 1'b0) begin n_err++; $display("FAIL mid_rst_misc: got data %h ovf %b und %b want 00 0 0", o_rd_data, o_overflow, o_underrun); end
      i_pkt_len = 16'd0;
      tick();
      #3 rst_n = 1'b1;
      tick();
      tick();
      n_vec++; if (o_send_req !== 1'b0 || o_busy !== 1'b0 || o_state !== 2'd0) begin n_err++; $display("FAIL mid_rst_after: got req %b busy %b state %0d want 0 0 0", o_send_req, o_busy, o_state); end
   endtask

`ifdef UDP_FIFO_TEST_PATTERN_EN
   task automatic test_pattern();
      for (int i = 0; i < 300; i++) begin
         n_vec++; if (o_rd_data !== 8'(i)) begin n_err++; $display("FAIL pattern_data[%0d]: got %h want %h", i, o_rd_data, 8'(i)); end
         n_vec++; if (o_empty !== 1'b0) begin n_err++; $display("FAIL pattern_empty[%0d]: got %b want 0", i, o_empty); end
         read_byte();
      end
      n_vec++; if (o_underrun !== 1'b0) begin n_err++; $display("FAIL pattern_underrun: got %b want 0", o_underrun); end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
`ifdef UDP_FIFO_TEST_PATTERN_EN
      test_pattern();
`else
      test_basic();
      test_full_overflow();
      test_pkt_req();
      test_back_to_back();
      test_underrun();
      test_reset_mid_send();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
